ps2_device_tx: RTL and testbench

- Device-side PS/2 keyboard transmitter. Serialises scan-code bytes onto a PS/2 clock/data pair.
- Feeds the UK101 core's PS/2 keyboard receiver (ps2Clk/ps2Data) from an on-chip source: OSD key injection, autotype/paste, or test stimulus.
- Byte-wide valid/ready input with a small FIFO; generates its own PS/2 clock from the system clock.

---
 rtl/ps2_device_tx.sv | 186 ++++++++++++++++++
 tb/tb_ps2_device_tx.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: queues scan-code bytes in a small FIFO and
// serialises each as an 11-bit frame (start, D0..D7, odd parity, stop) on a
// self-generated PS/2 clock. Every output is registered.
module ps2_device_tx #(
    parameter int unsigned CLK_DIV    = 2000,
    parameter int unsigned GAP_CYCLES = 4000,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          n_reset,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          ps2_clk,
    output logic                          ps2_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX);

    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic [1:0]    r_state;
    logic [CW-1:0] r_div;
    logic [3:0]    r_bit_idx;
    logic [10:0]   r_shift;

    logic          r_ps2_clk;
    logic          r_ps2_data;
    logic          r_in_ready;
    logic          r_busy;

    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_head;
    logic [AW:0]   w_count_next;
    logic [1:0]    w_state_next;
    logic [CW-1:0] w_div_next;
    logic [3:0]    w_bit_idx_next;
    logic [10:0]   w_shift_next;

    // r_in_ready tracks (r_count != FULL_COUNT), so a full FIFO never accepts a push.
    assign w_push = in_valid & r_in_ready;
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
    assign w_head = r_mem[r_rd_ptr];

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // FIFO storage; no reset needed since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    // Frame sequencer next state; the divider reloads on every state change.
    always_comb begin
        w_state_next   = r_state;
        w_div_next     = r_div;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    // Bit 0 goes out first: start, data LSB first, odd parity, stop.
                    w_shift_next   = {1'b1, ~^w_head, w_head, 1'b0};
                    w_bit_idx_next = '0;
                    w_div_next     = '0;
                    w_state_next   = S_HIGH;
                end
            end
            S_HIGH: begin
                if (r_div == DIV_LAST) begin
                    w_div_next   = '0;
                    w_state_next = S_LOW;
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
            S_LOW: begin
                if (r_div == DIV_LAST) begin
                    w_div_next = '0;
                    if (r_bit_idx == 4'd10) begin
                        w_state_next = S_GAP;
                    end else begin
                        w_shift_next   = {1'b1, r_shift[10:1]};
                        w_bit_idx_next = r_bit_idx + 1'b1;
                        w_state_next   = S_HIGH;
                    end
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
            S_GAP: begin
                if (r_div == GAP_LAST) begin
                    w_div_next   = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_div_next   = '0;
            end
        endcase
    end

    // Frame sequencer state registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '1;
        end else begin
            r_state   <= w_state_next;
            r_div     <= w_div_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
        end
    end

    // Registered outputs; the PS/2 pins trail the sequencer state by one cycle,
    // which keeps clock and data edges aligned with each other.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_ps2_clk  <= (r_state != S_LOW);
            r_ps2_data <= ((r_state == S_HIGH) || (r_state == S_LOW)) ? r_shift[0] : 1'b1;
            r_in_ready <= (w_count_next != FULL_COUNT);
            r_busy     <= (w_state_next != S_IDLE) || (w_count_next != '0);
        end
    end

    assign ps2_clk    = r_ps2_clk;
    assign ps2_data   = r_ps2_data;
    assign in_ready   = r_in_ready;
    assign busy       = r_busy;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx with a background PS/2 frame monitor.
module tb_ps2_device_tx;

    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int FCW        = $clog2(FIFO_DEPTH) + 1;

    logic           clk = 1'b0;
    logic           n_reset;
    logic [7:0]     in_data;
    logic           in_valid;
    logic           in_ready;
    logic           ps2_clk;
    logic           ps2_data;
    logic           busy;
    logic [FCW-1:0] fifo_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    ps2_device_tx #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state and decoded frames
    logic [10:0] q_bits[$];
    int          q_start[$];
    int          q_end[$];
    int          q_gap[$];
    int          half_err = 0;
    int          stab_err = 0;
    int          stray    = 0;

    initial begin : monitor
        logic        prev_clk;
        logic        prev_data;
        logic        in_frame;
        logic [10:0] shreg;
        int          nbits;
        int          run_len;
        int          t_start;
        int          t_last_end;
        int          gap_cur;
        int          hl;
        prev_clk   = 1'b1;
        prev_data  = 1'b1;
        in_frame   = 1'b0;
        shreg      = '0;
        nbits      = 0;
        run_len    = 0;
        t_start    = 0;
        t_last_end = -1;
        gap_cur    = -1;
        forever begin
            @(negedge clk);
            if (n_reset !== 1'b1) begin
                in_frame   = 1'b0;
                nbits      = 0;
                run_len    = 0;
                t_last_end = -1;
            end else if (ps2_clk != prev_clk) begin
                if (!ps2_clk) begin
                    if (in_frame && nbits < 11) begin
                        hl = (nbits == 0) ? (cyc - t_start) : run_len;
                        if (hl != CLK_DIV) half_err++;
                        if (ps2_data != prev_data) stab_err++;
                        shreg[nbits] = ps2_data;
                        nbits++;
                    end else begin
                        stray++;
                    end
                end else if (in_frame) begin
                    if (run_len != CLK_DIV) half_err++;
                    if (nbits == 11) begin
                        q_bits.push_back(shreg);
                        q_start.push_back(t_start);
                        q_end.push_back(cyc);
                        q_gap.push_back(gap_cur);
                        t_last_end = cyc;
                        in_frame   = 1'b0;
                    end
                end
                run_len = 1;
            end else begin
                run_len++;
                if (in_frame && ps2_data != prev_data) stab_err++;
                if (!in_frame && ps2_clk && prev_data && !ps2_data) begin
                    in_frame = 1'b1;
                    t_start  = cyc;
                    nbits    = 0;
                    gap_cur  = (t_last_end >= 0) ? (cyc - t_last_end) : -1;
                end
            end
            prev_clk  = ps2_clk;
            prev_data = ps2_data;
        end
    end

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [FCW-1:0] obs, input logic [FCW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Frame as sent on the wire, bit 0 first: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] mk(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    task automatic clear_q();
        q_bits.delete();
        q_start.delete();
        q_end.delete();
        q_gap.delete();
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (q_bits.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk_int("frames_received", q_bits.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk_bit("idle_reached", busy, 1'b0);
    endtask

    initial begin : stim
        logic [7:0]  pb[3];
        logic [10:0] pf[3];
        logic        pp[3];
        logic [7:0]  acc[$];
        int          t_push;
        int          next;
        int          k;
        int          bad;
        logic        saw_full;

        pb = '{8'h00, 8'hFF, 8'h01};
        pf = '{11'h600, 11'h7FE, 11'h402};
        pp = '{1'b1, 1'b1, 1'b0};

        // Power-on reset
        n_reset  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(negedge clk);
        #1;
        chk_bit("rst_ps2_clk", ps2_clk, 1'b1);
        chk_bit("rst_ps2_data", ps2_data, 1'b1);
        chk_bit("rst_in_ready", in_ready, 1'b1);
        chk_bit("rst_busy", busy, 1'b0);
        chk_cnt("rst_fifo_count", fifo_count, 3'd0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        repeat (20) @(negedge clk);
        chk_bit("post_rst_idle_clk", ps2_clk, 1'b1);
        chk_int("post_rst_no_frame", q_bits.size(), 0);

        // Single byte 0x1C: latency, content, half-periods and frame length
        clear_q();
        in_data  = 8'h1C;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        t_push   = cyc;
        chk_cnt("single_count_after_push", fifo_count, 3'd1);
        chk_bit("single_busy_after_push", busy, 1'b1);
        @(negedge clk);
        chk_cnt("single_count_after_pop", fifo_count, 3'd0);
        chk_bit("single_no_start_yet", ps2_data, 1'b1);
        wait_frames(1, 300);
        if (q_bits.size() >= 1) begin
            chk_frame("single_1C_frame", q_bits[0], 11'h438);
            chk_int("single_start_latency", q_start[0] - t_push, 2);
            chk_int("single_frame_length", q_end[0] - q_start[0], 22 * CLK_DIV);
        end
        wait_idle(100);

        // Parity extremes
        for (int i = 0; i < 3; i++) begin
            clear_q();
            in_data  = pb[i];
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            wait_frames(1, 300);
            if (q_bits.size() >= 1) begin
                chk_frame("parity_frame", q_bits[0], pf[i]);
                chk_bit("parity_bit", q_bits[0][9], pp[i]);
            end
            wait_idle(100);
        end

        // Back-to-back 0xF0, 0x12 with a full inter-frame gap
        clear_q();
        in_data  = 8'hF0;
        in_valid = 1'b1;
        @(negedge clk);
        in_data  = 8'h12;
        @(negedge clk);
        in_valid = 1'b0;
        chk_cnt("b2b_count", fifo_count, 3'd1);
        wait_frames(2, 600);
        if (q_bits.size() >= 2) begin
            chk_frame("b2b_F0_frame", q_bits[0], 11'h7E0);
            chk_frame("b2b_12_frame", q_bits[1], 11'h624);
            chk_bit("b2b_F0_parity", q_bits[0][9], 1'b1);
            chk_bit("b2b_12_parity", q_bits[1][9], 1'b1);
            chk_range("b2b_gap", q_gap[1], GAP_CYCLES + 1, GAP_CYCLES + 4);
        end
        wait_idle(100);

        // Push on the pop cycle: count holds at 1 and data is preserved
        clear_q();
        in_data  = 8'h33;
        in_valid = 1'b1;
        @(negedge clk);
        chk_cnt("pp_count_before", fifo_count, 3'd1);
        in_data = 8'h55;
        @(negedge clk);
        in_valid = 1'b0;
        chk_cnt("pp_count_after", fifo_count, 3'd1);
        chk_bit("pp_in_ready", in_ready, 1'b1);
        wait_frames(2, 600);
        if (q_bits.size() >= 2) begin
            chk_frame("pp_first_frame", q_bits[0], 11'h666);
            chk_frame("pp_55_frame", q_bits[1], 11'h6AA);
        end
        wait_idle(100);

        // Saturate the FIFO with 0xA0..0xA7 while transmitting
        clear_q();
        acc.delete();
        next     = 0;
        k        = 0;
        saw_full = 1'b0;
        in_data  = 8'hA0;
        in_valid = 1'b1;
        while (next < 8 && k < 3000) begin
            chk_bit("full_in_ready", in_ready, (fifo_count != 3'(FIFO_DEPTH)));
            if (fifo_count == 3'(FIFO_DEPTH)) saw_full = 1'b1;
            if (in_ready) begin
                acc.push_back(in_data);
                next++;
            end
            @(negedge clk);
            k++;
            in_data  = 8'(8'hA0 + next);
            in_valid = (next < 8);
        end
        in_valid = 1'b0;
        chk_int("full_all_accepted", next, 8);
        chk_bit("full_reached", saw_full, 1'b1);
        wait_frames(8, 2000);
        if (q_bits.size() >= 8 && acc.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk_int("full_accept_order", int'(acc[i]), 32'hA0 + i);
                chk_frame("full_tx_frame", q_bits[i], mk(8'(8'hA0 + i)));
            end
            for (int i = 1; i < 8; i++) begin
                chk_range("full_gap", q_gap[i], GAP_CYCLES + 1, GAP_CYCLES + 4);
            end
            chk_bit("full_busy_after_stop", busy, 1'b1);
            k = 0;
            while (busy !== 1'b0 && k < 200) begin
                @(negedge clk);
                k++;
            end
            chk_range("full_busy_fall", cyc - q_end[7], GAP_CYCLES - 1, GAP_CYCLES + 1);
        end
        wait_idle(100);

        // Reset mid-frame with a second byte queued
        clear_q();
        in_data  = 8'h1C;
        in_valid = 1'b1;
        @(negedge clk);
        in_data  = 8'h2A;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (ps2_clk !== 1'b0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk_bit("mid_clk_low", ps2_clk, 1'b0);
        chk_bit("mid_start_bit", ps2_data, 1'b0);
        chk_cnt("mid_count", fifo_count, 3'd1);
        #2;
        n_reset = 1'b0;
        #1;
        chk_bit("mid_rst_ps2_clk", ps2_clk, 1'b1);
        chk_bit("mid_rst_ps2_data", ps2_data, 1'b1);
        chk_cnt("mid_rst_count", fifo_count, 3'd0);
        chk_bit("mid_rst_in_ready", in_ready, 1'b1);
        chk_bit("mid_rst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk_int("mid_no_stray_activity", bad, 0);
        chk_int("mid_no_frame", q_bits.size(), 0);

        // Monitor-wide timing and stability counters
        chk_int("half_period_errors", half_err, 0);
        chk_int("data_stability_errors", stab_err, 0);
        chk_int("stray_clock_edges", stray, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
